// File: rtl/layer4_conv_scheduler.sv
// Layer-4 conv sequencer: per channel, one bias-load cycle, then one pixel issued per cycle.
// Issue is combinational from the registered state; out_ready=0 stalls the pixel walk.
module layer4_conv_scheduler #(
    parameter int IMG_W      = 112,
    parameter int IMG_H      = 112,
    parameter int OUT_CH     = 128,
    parameter int PIPE_DEPTH = 6,
    localparam int CH_W = (OUT_CH > 1) ? $clog2(OUT_CH) : 1,
    localparam int X_W  = (IMG_W  > 1) ? $clog2(IMG_W)  : 1,
    localparam int Y_W  = (IMG_H  > 1) ? $clog2(IMG_H)  : 1,
    localparam int IF_W = $clog2(PIPE_DEPTH + 1)
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_start,
    input  logic            i_out_ready,
    input  logic            i_valid_ret,
    output logic            o_valid_in_bias,
    output logic            o_bias_load,
    output logic [CH_W-1:0] o_ch_idx,
    output logic [X_W-1:0]  o_pix_x,
    output logic [Y_W-1:0]  o_pix_y,
    output logic [IF_W-1:0] o_inflight,
    output logic            o_busy,
    output logic            o_done,
    output logic            o_err
);

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD_BIAS, S_RUN, S_DRAIN, S_DONE
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [CH_W-1:0] r_ch_idx;
    logic [X_W-1:0]  r_pix_x;
    logic [Y_W-1:0]  r_pix_y;
    logic [IF_W-1:0] r_inflight;
    logic            r_err;

    logic w_issue;
    logic w_last_x;
    logic w_last_y;
    logic w_last_ch;

    assign w_issue   = (r_state == S_RUN) & i_out_ready;
    assign w_last_x  = (r_pix_x  == X_W'(IMG_W - 1));
    assign w_last_y  = (r_pix_y  == Y_W'(IMG_H - 1));
    assign w_last_ch = (r_ch_idx == CH_W'(OUT_CH - 1));

    always_ff @(posedge i_clk) begin
        if (i_rst) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:      if (i_start) w_state_nxt = S_LOAD_BIAS;
            S_LOAD_BIAS: w_state_nxt = S_RUN;
            S_RUN:       if (w_issue && w_last_x && w_last_y)
                             w_state_nxt = w_last_ch ? S_DRAIN : S_LOAD_BIAS;
            S_DRAIN:     if (r_inflight == '0) w_state_nxt = S_DONE;
            S_DONE:      w_state_nxt = S_IDLE;
            default:     w_state_nxt = S_IDLE;
        endcase
    end

    // Pixel/channel walk; the final channel index is held so it stays visible through drain.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_ch_idx <= '0;
            r_pix_x  <= '0;
            r_pix_y  <= '0;
        end else if (r_state == S_IDLE && i_start) begin
            r_ch_idx <= '0;
            r_pix_x  <= '0;
            r_pix_y  <= '0;
        end else if (w_issue) begin
            if (w_last_x) begin
                r_pix_x <= '0;
                if (w_last_y) begin
                    r_pix_y <= '0;
                    if (!w_last_ch) r_ch_idx <= r_ch_idx + CH_W'(1);
                end else begin
                    r_pix_y <= r_pix_y + Y_W'(1);
                end
            end else begin
                r_pix_x <= r_pix_x + X_W'(1);
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_inflight <= '0;
            r_err      <= 1'b0;
        end else begin
            if (i_valid_ret && r_inflight == '0) r_err <= 1'b1;
            case ({w_issue, i_valid_ret})
                2'b10:   r_inflight <= r_inflight + IF_W'(1);
                2'b01:   if (r_inflight != '0) r_inflight <= r_inflight - IF_W'(1);
                default: r_inflight <= r_inflight;
            endcase
        end
    end

    assign o_valid_in_bias = w_issue;
    assign o_bias_load     = (r_state == S_LOAD_BIAS);
    assign o_done          = (r_state == S_DONE);
    assign o_busy          = (r_state != S_IDLE);
    assign o_ch_idx        = r_ch_idx;
    assign o_pix_x         = r_pix_x;
    assign o_pix_y         = r_pix_y;
    assign o_inflight      = r_inflight;
    assign o_err           = r_err;

endmodule

// File: tb/tb_layer4_conv_scheduler.sv
// Directed bench for layer4_conv_scheduler with a 4x2x2 layer and a 6-deep valid delay line.
module tb_layer4_conv_scheduler;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       out_ready;
    logic       inj;
    logic [5:0] dl;
    logic       valid_ret;

    logic       vib;
    logic       bias_load;
    logic       ch_idx;
    logic [1:0] pix_x;
    logic       pix_y;
    logic [2:0] inflight;
    logic       busy;
    logic       done;
    logic       err;

    int n_pass  = 0;
    int n_total = 0;

    layer4_conv_scheduler #(
        .IMG_W(4), .IMG_H(2), .OUT_CH(2), .PIPE_DEPTH(6)
    ) dut (
        .i_clk(clk),
        .i_rst(rst),
        .i_start(start),
        .i_out_ready(out_ready),
        .i_valid_ret(valid_ret),
        .o_valid_in_bias(vib),
        .o_bias_load(bias_load),
        .o_ch_idx(ch_idx),
        .o_pix_x(pix_x),
        .o_pix_y(pix_y),
        .o_inflight(inflight),
        .o_busy(busy),
        .o_done(done),
        .o_err(err)
    );

    always #5 clk = ~clk;

    // Pipeline stand-in: issue comes back 6 cycles later; flushed by reset.
    always_ff @(posedge clk) begin
        if (rst) dl <= '0;
        else     dl <= {dl[4:0], vib};
    end
    assign valid_ret = dl[5] | inj;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One full run, start at c=0. b2: second bias_load cycle, dc: done cycle, stall window [s_lo,s_hi].
    task automatic run_check(input int s_lo, input int s_hi, input int b2, input int dc,
                             input bit extra_start);
        int  k      = 0;
        int  n_iss  = 0;
        int  n_done = 0;
        bit  exp_iss;
        for (int c = 0; c <= dc; c++) begin
            start     = (c == 0) || (extra_start && (c == 5 || c == 21));
            out_ready = !(c >= s_lo && c <= s_hi);
            #1;
            exp_iss = (c >= 2 && c < b2 && out_ready) || (c > b2 && c <= b2 + 8);
            chk($sformatf("issue@%0d", c), 32'(vib), 32'(exp_iss));
            chk($sformatf("bias_load@%0d", c), 32'(bias_load), 32'(c == 1 || c == b2));
            chk($sformatf("done@%0d", c), 32'(done), 32'(c == dc));
            chk($sformatf("busy@%0d", c), 32'(busy), 32'(c >= 1));
            chk($sformatf("inflight_max@%0d", c), 32'(inflight <= 3'd6), 32'd1);
            if (exp_iss) begin
                chk($sformatf("pix_x@%0d", c), 32'(pix_x), 32'(k % 4));
                chk($sformatf("pix_y@%0d", c), 32'(pix_y), 32'((k / 4) % 2));
                chk($sformatf("ch@%0d", c), 32'(ch_idx), 32'(k / 8));
                k++;
            end
            if (s_lo > dc && (c == 8 || c == 9))
                chk($sformatf("inflight_steady@%0d", c), 32'(inflight), 32'd6);
            if (c == dc - 2) chk("inflight_last_ret", 32'(inflight), 32'd1);
            if (c == dc - 1) chk("inflight_drained", 32'(inflight), 32'd0);
            n_iss  += int'(vib);
            n_done += int'(done);
            tick();
        end
        start = 1'b0;
        chk("total_issues", 32'(n_iss), 32'd16);
        chk("done_pulses", 32'(n_done), 32'd1);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; out_ready = 1'b1; inj = 1'b0;
        tick(); tick(); tick();
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_vib", 32'(vib), 32'd0);
        chk("rst_bias_load", 32'(bias_load), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_ch", 32'(ch_idx), 32'd0);
        chk("rst_pix", 32'({pix_y, pix_x}), 32'd0);
        chk("rst_inflight", 32'(inflight), 32'd0);
        rst = 1'b0;
        tick();

        // Baseline, then 3-cycle stall in channel 0.
        run_check(99, 0, 10, 26, 1'b0);
        run_check(4, 6, 13, 29, 1'b0);
        // Stray starts during RUN/DRAIN, then restart in the cycle right after DONE.
        run_check(99, 0, 10, 26, 1'b1);
        run_check(99, 0, 10, 26, 1'b0);

        // Reset mid channel 0.
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (7) tick();
        chk("mid_pix_x", 32'(pix_x), 32'd2);
        chk("mid_pix_y", 32'(pix_y), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        chk("rst9_busy", 32'(busy), 32'd0);
        chk("rst9_vib", 32'(vib), 32'd0);
        chk("rst9_ch", 32'(ch_idx), 32'd0);
        chk("rst9_pix_x", 32'(pix_x), 32'd0);
        chk("rst9_pix_y", 32'(pix_y), 32'd0);
        chk("rst9_inflight", 32'(inflight), 32'd0);
        tick();
        run_check(99, 0, 10, 26, 1'b0);
        chk("err_clean", 32'(err), 32'd0);

        // Spurious return while idle.
        inj = 1'b1;
        tick();
        inj = 1'b0;
        chk("err_set", 32'(err), 32'd1);
        chk("err_inflight", 32'(inflight), 32'd0);
        repeat (3) tick();
        chk("err_sticky", 32'(err), 32'd1);
        chk("err_idle_busy", 32'(busy), 32'd0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("err_cleared", 32'(err), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/layer4_conv_scheduler.md
Name: layer4_conv_scheduler

Overview:
Sequencer for the layer-4 convolution datapath: walks output channels and output pixels and issues one pixel per cycle into the bias/MAC valid pipeline. Per channel it first requests a bias load, then issues every pixel of the channel. It tracks in-flight work using the pipeline's returned valid, and drains before signalling completion. It sits between the layer-level start/done handshake and the 6-cycle layer-4 valid pipeline.

Parameters:
IMG_W, 112, output feature-map width (pixels per row)
IMG_H, 112, output feature-map height
OUT_CH, 128, output channels
PIPE_DEPTH, 6, cycles from valid_in_bias to returned valid (5 stages + output register)

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
start  in  1  one-cycle request to run the layer; sampled only in IDLE
out_ready  in  1  downstream has >= PIPE_DEPTH free slots; gates issue
valid_ret  in  1  returned valid from the layer-4 pipeline output
valid_in_bias  out  1  issue strobe into the pipeline
bias_load  out  1  one-cycle bias fetch request for ch_idx
ch_idx  out  clog2(OUT_CH)  current output channel (also the bias address)
pix_x  out  clog2(IMG_W)  column of the pixel being issued
pix_y  out  clog2(IMG_H)  row of the pixel being issued
inflight  out  clog2(PIPE_DEPTH+1)  issued-but-not-returned count
busy  out  1  high in every state except IDLE
done  out  1  one-cycle completion pulse
err  out  1  sticky: valid_ret seen with inflight==0

Behaviour:
- Reset (synchronous): state=IDLE; ch_idx, pix_x, pix_y, inflight = 0; bias_load, done, err = 0. Reset mid-run abandons the run immediately; the next run starts again at channel 0.
- FSM states: IDLE, LOAD_BIAS, RUN, DRAIN, DONE.
- IDLE: start=1 -> LOAD_BIAS; counters cleared to 0. start in any other state is ignored.
- LOAD_BIAS: lasts exactly 1 cycle; bias_load=1 (registered, decoded from state); -> RUN.
- RUN: valid_in_bias = (state==RUN) & out_ready (combinational from registered state). Counters hold when out_ready=0.
- Pixel advance on each issue: pix_x++. At IMG_W-1, pix_x wraps to 0 and pix_y++.
- Issue of (IMG_W-1, IMG_H-1): pix_x and pix_y wrap to 0.
  - If ch_idx < OUT_CH-1: ch_idx++ and -> LOAD_BIAS.
  - Otherwise: -> DRAIN, and ch_idx holds.
- DRAIN: valid_in_bias=0. When inflight==0 at a clock edge -> DONE.
- DONE: done=1 for 1 cycle; -> IDLE.
- inflight update rules:
  - +1 on issue only.
  - -1 on valid_ret only.
  - Unchanged when both occur in the same cycle.
  - valid_ret with inflight==0: counter stays 0 and err is set; err clears only on rst.
- inflight never exceeds PIPE_DEPTH under a non-stalling pipeline. The bench checks this as an assertion.
- busy = (state != IDLE).
- All index arithmetic is unsigned, compared against parameter-1 in full width; no overflow beyond the parameter ranges.

Test Plan:
1. Params W=4, H=2, CH=2, PIPE_DEPTH=6; valid_ret = valid_in_bias delayed 6 cycles; out_ready=1; start in cycle 0 -> bias_load in cycles 1 and 10; valid_in_bias in cycles 2-9 and 11-18 (16 issues); (x,y) sequence (0,0),(1,0),(2,0),(3,0),(0,1)...(3,1) per channel; last valid_ret in cycle 24; inflight 0 in cycle 25; done in cycle 26 only; busy falls in cycle 27.
2. Same params, out_ready=0 during cycles 4-6 -> no issue in those cycles, counters hold; pixel sequence otherwise unchanged; done delayed by exactly 3 cycles to cycle 29.
3. start pulses during RUN and DRAIN -> ignored; exactly 16 issues, one done pulse. A new start in the cycle after DONE -> second full run from ch 0.
4. rst asserted in cycle 8 (mid channel 0) -> cycle 9: state IDLE, valid_in_bias=0, ch_idx=pix_x=pix_y=inflight=0, busy=0. Later start -> full 16-issue run.
5. Inject a valid_ret pulse while IDLE with inflight=0 -> err=1 and stays 1; inflight stays 0; err clears only after rst.
6. Simultaneous issue and valid_ret (steady state, cycles 8-9 of test 1) -> inflight stays at 6; it never exceeds 6 throughout the run.
